lcd_capture: RTL and testbench



---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_fb_ram.sv | 36 +++
 rtl/lcd_capture.sv | 183 ++++++++++++++++++
 tb/tb_lcd_capture.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared geometry, widths, capture FSM encoding and framebuffer address helper
// for the LCD capture block.
package lcd_pkg;

    localparam int unsigned LCD_WIDTH          = 160;
    localparam int unsigned LCD_HEIGHT         = 144;
    localparam int unsigned LCD_BYTES_PER_LINE = LCD_WIDTH / 4;
    localparam int unsigned LCD_FB_BYTES       = LCD_BYTES_PER_LINE * LCD_HEIGHT;

    localparam int unsigned LCD_COORD_W = 8;
    localparam int unsigned LCD_COL_W   = 2;
    localparam int unsigned LCD_BYTE_W  = 8;
    localparam int unsigned LCD_ADDR_W  = 13;
    localparam int unsigned LCD_COUNT_W = 16;
    localparam int unsigned LCD_XBYTE_W = LCD_COORD_W - 2;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_ACTIVE = 2'd1,
        S_VBLANK = 2'd2
    } lcd_state_t;

    typedef struct packed {
        logic [LCD_ADDR_W-1:0] addr;
        logic [LCD_BYTE_W-1:0] data;
    } lcd_fb_wr_t;

    // Byte address of packed pixel group xb on line y.
    function automatic logic [LCD_ADDR_W-1:0] lcd_fb_addr(
        input logic [LCD_COORD_W-1:0] y,
        input logic [LCD_XBYTE_W-1:0] xb
    );
        return LCD_ADDR_W'(y) * LCD_ADDR_W'(LCD_BYTES_PER_LINE) + LCD_ADDR_W'(xb);
    endfunction

endpackage

// File: rtl/lcd_fb_ram.sv
// Simple dual-port byte RAM: one write port, one registered read-before-write
// read port; addresses beyond DEPTH read back as zero.
module lcd_fb_ram
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = LCD_FB_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [LCD_ADDR_W-1:0] wr_addr,
    input  logic [LCD_BYTE_W-1:0] wr_data,
    input  logic [LCD_ADDR_W-1:0] rd_addr,
    output logic [LCD_BYTE_W-1:0] rd_data
);

    logic [LCD_BYTE_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_addr < LCD_ADDR_W'(DEPTH)) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/lcd_capture.sv
// Captures the LCD pixel stream into a packed 2bpp framebuffer and tracks frames.
// Define LCD_CAPTURE_DBUF_EN for a tear-free double-buffered framebuffer.
module lcd_capture
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_write,
    input  logic [1:0]  lcd_col,
    input  logic [7:0]  lcd_x,
    input  logic [7:0]  lcd_y,
    input  logic        lcd_hblank,
    input  logic        lcd_vblank,
    input  logic [12:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_seq,
    output logic        err_range
);

    lcd_state_t                state_q, state_d;
    logic                      vblank_q;
    logic                      vb_rise, vb_fall;
    logic [LCD_BYTE_W-1:0]     packer_q, packer_d, merged;
    logic [LCD_COORD_W-1:0]    exp_x_q, exp_x_d, exp_y_q, exp_y_d;
    logic                      err_seq_d, err_range_d, frame_done_d;
    logic [LCD_COUNT_W-1:0]    frame_count_d;
    logic                      in_range, in_seq;
    logic [1:0]                lane;
    logic                      wr_en_c;
    lcd_fb_wr_t                wr_c;
    logic                      hblank_unused;

    // Blank level is informational; sequencing follows the coordinates.
    assign hblank_unused = lcd_hblank;

    assign vb_rise  = lcd_vblank & ~vblank_q;
    assign vb_fall  = ~lcd_vblank & vblank_q;
    assign lane     = lcd_x[1:0];
    assign in_range = (lcd_x < LCD_COORD_W'(LCD_WIDTH)) && (lcd_y < LCD_COORD_W'(LCD_HEIGHT));
    assign in_seq   = (lcd_x == exp_x_q) && (lcd_y == exp_y_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, packer and commit logic; a pixel is handled before a same-cycle frame end.
    always_comb begin
        state_d       = state_q;
        packer_d      = packer_q;
        exp_x_d       = exp_x_q;
        exp_y_d       = exp_y_q;
        err_seq_d     = err_seq;
        err_range_d   = err_range;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count;
        wr_en_c       = 1'b0;
        wr_c          = '0;
        merged        = packer_q;

        unique case (state_q)
            S_SYNC, S_VBLANK: begin
                if (vb_fall) begin
                    state_d = S_ACTIVE;
                    exp_x_d = '0;
                    exp_y_d = '0;
                end
            end
            S_ACTIVE: begin
                if (lcd_write) begin
                    if (!in_range) begin
                        err_range_d = 1'b1;
                    end else begin
                        if (!in_seq) begin
                            err_seq_d = 1'b1;
                            merged    = '0;
                        end
                        merged[{lane, 1'b0} +: LCD_COL_W] = lcd_col;
                        if (lane == 2'd3) begin
                            wr_en_c   = 1'b1;
                            wr_c.addr = lcd_fb_addr(lcd_y, lcd_x[LCD_COORD_W-1:2]);
                            wr_c.data = merged;
                            packer_d  = '0;
                        end else begin
                            packer_d  = merged;
                        end
                        if (lcd_x == LCD_COORD_W'(LCD_WIDTH - 1)) begin
                            exp_x_d = '0;
                            exp_y_d = lcd_y + 8'd1;
                        end else begin
                            exp_x_d = lcd_x + 8'd1;
                            exp_y_d = lcd_y;
                        end
                    end
                end
                if (vb_rise) begin
                    state_d       = S_VBLANK;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count + 16'd1;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q    <= 1'b0;
            packer_q    <= '0;
            exp_x_q     <= '0;
            exp_y_q     <= '0;
            err_seq     <= 1'b0;
            err_range   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            vblank_q    <= lcd_vblank;
            packer_q    <= packer_d;
            exp_x_q     <= exp_x_d;
            exp_y_q     <= exp_y_d;
            err_seq     <= err_seq_d;
            err_range   <= err_range_d;
            frame_done  <= frame_done_d;
            frame_count <= frame_count_d;
        end
    end

`ifdef LCD_CAPTURE_DBUF_EN
    logic                  front_q, rd_sel_q;
    logic [LCD_BYTE_W-1:0] rd_data0, rd_data1;

    // Front select flips with frame_done; rd_sel_q remembers which buffer each read used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q  <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            front_q  <= front_q ^ frame_done_d;
            rd_sel_q <= front_q;
        end
    end

    lcd_fb_ram #(.DEPTH(LCD_FB_BYTES)) u_fb0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en_c & front_q),
        .wr_addr (wr_c.addr),
        .wr_data (wr_c.data),
        .rd_addr (rd_addr),
        .rd_data (rd_data0)
    );

    lcd_fb_ram #(.DEPTH(LCD_FB_BYTES)) u_fb1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en_c & ~front_q),
        .wr_addr (wr_c.addr),
        .wr_data (wr_c.data),
        .rd_addr (rd_addr),
        .rd_data (rd_data1)
    );

    assign rd_data = rd_sel_q ? rd_data1 : rd_data0;
`else
    lcd_fb_ram #(.DEPTH(LCD_FB_BYTES)) u_fb (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en_c),
        .wr_addr (wr_c.addr),
        .wr_data (wr_c.data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// Randomized scoreboard bench for lcd_capture with a pixel-level framebuffer model.
module tb_lcd_capture;

    localparam int W   = 160;
    localparam int H   = 144;
    localparam int BPL = 40;
    localparam int FBB = 5760;
`ifdef LCD_CAPTURE_DBUF_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        lcd_write;
    logic [1:0]  lcd_col;
    logic [7:0]  lcd_x;
    logic [7:0]  lcd_y;
    logic        lcd_hblank;
    logic        lcd_vblank;
    logic [12:0] rd_addr;
    logic [7:0]  rd_data;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        err_seq;
    logic        err_range;

    lcd_capture dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcd_write   (lcd_write),
        .lcd_col     (lcd_col),
        .lcd_x       (lcd_x),
        .lcd_y       (lcd_y),
        .lcd_hblank  (lcd_hblank),
        .lcd_vblank  (lcd_vblank),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err_seq     (err_seq),
        .err_range   (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit known;
        int addr;
        int data;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      fd_q[$];

    // Reference model state: which pixel is expected next, pending byte lanes, buffers.
    bit capturing;
    bit prev_vb;
    int ex, ey;
    int lanes[4];
    int fb[2][FBB];
    bit fb_known[2][FBB];
    int front;
    int m_count;
    bit m_seq, m_rng;
    bit rd_req = 1'b0;
    bit req_d  = 1'b0;
    int col_x7;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic model_reset();
        capturing = 1'b0;
        prev_vb   = 1'b0;
        ex = 0;
        ey = 0;
        for (int i = 0; i < 4; i++) lanes[i] = 0;
        front   = 0;
        m_count = 0;
        m_seq   = 1'b0;
        m_rng   = 1'b0;
    endtask

    task automatic model_step(input bit wr, input int col, input int x, input int y, input bit vb);
        bit rise, fall;
        int addr, back;
        rise    = vb && !prev_vb;
        fall    = !vb && prev_vb;
        prev_vb = vb;
        if (capturing && wr) begin
            if (x >= W || y >= H) begin
                m_rng = 1'b1;
            end else begin
                if (x != ex || y != ey) begin
                    m_seq = 1'b1;
                    for (int i = 0; i < 4; i++) lanes[i] = 0;
                end
                lanes[x % 4] = col;
                if (x % 4 == 3) begin
                    addr = y * BPL + x / 4;
                    back = (NBUF == 2) ? 1 - front : 0;
                    fb[back][addr]       = lanes[0] + 4 * lanes[1] + 16 * lanes[2] + 64 * lanes[3];
                    fb_known[back][addr] = 1'b1;
                    for (int i = 0; i < 4; i++) lanes[i] = 0;
                end
                if (x == W - 1) begin
                    ex = 0;
                    ey = y + 1;
                end else begin
                    ex = x + 1;
                    ey = y;
                end
            end
        end
        if (capturing && rise) begin
            capturing = 1'b0;
            m_count   = (m_count + 1) % 65536;
            fd_q.push_back(m_count);
            if (NBUF == 2) front = 1 - front;
        end else if (!capturing && fall) begin
            capturing = 1'b1;
            ex = 0;
            ey = 0;
        end
    endtask

    // One clock of stimulus; rexp < 0 means the model supplies the read expectation.
    task automatic cycle(input bit wr, input int col, input int x, input int y, input bit vb,
                         input bit rd, input int ra, input int rexp);
        rd_exp_t e;
        @(posedge clk);
        #1;
        lcd_write  = wr;
        lcd_col    = 2'(col);
        lcd_x      = 8'(x);
        lcd_y      = 8'(y);
        lcd_vblank = vb;
        rd_addr    = 13'(ra);
        rd_req     = rd;
        if (rd) begin
            e.addr = ra;
            if (rexp >= 0) begin
                e.known = 1'b1;
                e.data  = rexp;
            end else if (ra >= FBB) begin
                e.known = 1'b1;
                e.data  = 0;
            end else begin
                e.known = fb_known[front][ra];
                e.data  = fb[front][ra];
            end
            rd_q.push_back(e);
        end
        model_step(wr, col, x, y, vb);
    endtask

    task automatic idle(input int n, input bit vb);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, vb, 1'b0, 0, -1);
    endtask

    task automatic rd(input int a, input int e, input bit vb);
        cycle(1'b0, 0, 0, 0, vb, 1'b1, a, e);
    endtask

    // mode 0: col=(x+y)%4; mode 1: random col. skip_x drops a pixel, oob_x injects x=160.
    task automatic draw_line(input int y, input int mode, input int skip_x, input int oob_x);
        int col;
        lcd_hblank = 1'b0;
        for (int x = 0; x < W; x++) begin
            if (x == oob_x) cycle(1'b1, int'($urandom_range(0, 3)), W, y, 1'b0, 1'b0, 0, -1);
            if (x == skip_x) continue;
            col = (mode == 0) ? (x + y) % 4 : int'($urandom_range(0, 3));
            if (skip_x >= 0 && x == skip_x + 1) col_x7 = col;
            cycle(1'b1, col, x, y, 1'b0, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 5799)), -1);
        end
        lcd_hblank = 1'b1;
        idle(int'($urandom_range(1, 3)), 1'b0);
    endtask

    task automatic flags_check(input string tag, input int cnt);
        @(negedge clk);
        check({tag, "_frame_count"}, int'(frame_count), cnt);
        check({tag, "_err_seq"}, int'(err_seq), int'(m_seq));
        check({tag, "_err_range"}, int'(err_range), int'(m_rng));
    endtask

    // Monitor: pops the scoreboard whenever a read returns or frame_done pulses.
    always @(posedge clk) req_d <= rd_req;

    always @(negedge clk) begin
        rd_exp_t e;
        int fc;
        if (req_d) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                e = rd_q.pop_front();
                if (e.known) check($sformatf("rd_data[%0d]", e.addr), int'(rd_data), e.data);
            end
        end
        if (frame_done === 1'b1) begin
            if (fd_q.size() == 0) begin
                check("frame_done_unexpected", 1, 0);
            end else begin
                fc = fd_q.pop_front();
                check("frame_done_count", int'(frame_count), fc);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        lcd_write  = 1'b0;
        lcd_col    = '0;
        lcd_x      = '0;
        lcd_y      = '0;
        lcd_hblank = 1'b0;
        lcd_vblank = 1'b0;
        rd_addr    = '0;
        col_x7     = 0;
        model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < FBB; a++) begin
                fb[b][a]       = 0;
                fb_known[b][a] = 1'b0;
            end

        repeat (2) @(negedge clk);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_frame_count", int'(frame_count), 0);
        check("reset_err_seq", int'(err_seq), 0);
        check("reset_err_range", int'(err_range), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Writes before the first vblank fall are ignored.
        for (int x = 0; x < 20; x++) cycle(1'b1, int'($urandom_range(0, 3)), x, 0, 1'b0, 1'b0, 0, -1);
        flags_check("pre_sync", 0);

        // Frame 1: full raster with col=(x+y)%4.
        idle(4, 1'b1);
        for (int y = 0; y < H; y++) draw_line(y, 0, -1, -1);
        idle(2, 1'b1);
        rd(0, 'hE4, 1'b1);
        rd(41, 'h39, 1'b1);
        rd(6000, 0, 1'b1);
        rd(FBB, 0, 1'b1);
        for (int i = 0; i < 8; i++) rd(int'($urandom_range(0, 5759)), -1, 1'b1);
        flags_check("frame1", 1);

        // Frame 2: random shades, a skipped pixel on line 3 and an out-of-range pixel on line 10.
        idle(2, 1'b0);
        for (int y = 0; y < 12; y++) begin
            draw_line(y, 1, (y == 3) ? 6 : -1, (y == 10) ? 20 : -1);
            if (y == 6) begin
                rd(0, -1, 1'b0);
`ifdef LCD_CAPTURE_DBUF_EN
                rd(0, 'hE4, 1'b0);
`endif
            end
        end
        idle(2, 1'b1);
        rd(0, -1, 1'b1);
        rd(3 * BPL + 1, col_x7 * 64, 1'b1);
        for (int i = 0; i < 8; i++) rd(int'($urandom_range(0, 479)), -1, 1'b1);
        flags_check("frame2", 2);
        check("frame2_err_seq_set", int'(err_seq), 1);
        check("frame2_err_range_set", int'(err_range), 1);

        // Frame 3 interrupted by reset mid-line.
        idle(2, 1'b0);
        for (int x = 0; x < 10; x++) cycle(1'b1, int'($urandom_range(0, 3)), x, 0, 1'b0, 1'b0, 0, -1);
        @(negedge clk);
        #1;
        rst_n     = 1'b0;
        lcd_write = 1'b0;
        rd_req    = 1'b0;
        model_reset();
        #2;
        check("midreset_rd_data", int'(rd_data), 0);
        check("midreset_frame_done", int'(frame_done), 0);
        check("midreset_frame_count", int'(frame_count), 0);
        check("midreset_err_seq", int'(err_seq), 0);
        check("midreset_err_range", int'(err_range), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int x = 10; x < 40; x++) cycle(1'b1, int'($urandom_range(0, 3)), x + 3, 0, 1'b0, 1'b0, 0, -1);
        cycle(1'b1, 0, 200, 0, 1'b0, 1'b0, 0, -1);
        flags_check("post_reset", 0);

        // Short frame after resync.
        idle(3, 1'b1);
        idle(1, 1'b0);
        for (int y = 0; y < 2; y++) draw_line(y, 1, -1, -1);
        idle(2, 1'b1);
        for (int a = 0; a < 6; a++) rd(a, -1, 1'b1);
        rd(BPL + 7, -1, 1'b1);
        flags_check("frame4", 1);

        idle(4, 1'b1);
        check("pending_frame_done", fd_q.size(), 0);
        check("pending_reads", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
